// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit scheduler and its arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4
  } sched_state_e;

  localparam int unsigned NB_DATA_DEF = 8;
  localparam logic [3:0]  HDR_TAG_DEF = 4'hA;

  // Index width for an n-entry one-hot vector; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping.
module rr_arbiter import uart_pkg::*; #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  // Two passes: indices above the pointer first, then the wrapped range.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i > 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i <= 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte streams.
module uart_tx_sched import uart_pkg::*; #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [3:0]  HDR_TAG = HDR_TAG_DEF,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned NB_TO   = 10
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  input  logic [N_REQ-1:0]         i_req_last,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic                     o_err_timeout
);

  localparam int unsigned IDW = id_width(N_REQ);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT - 1);

  sched_state_e       state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   ready_q;
  logic [IDW-1:0]     gid_q;
  logic [IDW-1:0]     ptr_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               last_q;
  logic               hdr_q;
  logic               busy_q;
  logic               err_q;
  logic [NB_TO-1:0]   to_cnt_q;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;

  logic               gnt_vld_c;
  logic [NB_DATA-1:0] gnt_data_c;
  logic               gnt_last_c;
  logic [7:0]         hdr_byte_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Select the granted requester's lane.
  always_comb begin
    gnt_vld_c  = 1'b0;
    gnt_data_c = '0;
    gnt_last_c = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gid_q == IDW'(i)) begin
        gnt_vld_c  = i_req_valid[i];
        gnt_data_c = i_req_data[i*NB_DATA +: NB_DATA];
        gnt_last_c = i_req_last[i];
      end
    end
  end

  // Header byte for the requester being granted now.
  always_comb begin
    hdr_byte_c = {HDR_TAG, 4'(arb_idx)};
  end

  // Scheduler FSM; start is raised on entry to HDR/SEND so data and strobe align.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ready_q    <= '0;
      gid_q      <= '0;
      ptr_q      <= IDW'(N_REQ - 1);
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      hdr_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      ready_q    <= '0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q  <= arb_gnt;
            gid_q    <= arb_idx;
            busy_q   <= 1'b1;
            to_cnt_q <= '0;
            if (HDR_EN) begin
              tx_data_q  <= NB_DATA'(hdr_byte_c);
              tx_start_q <= 1'b1;
              hdr_q      <= 1'b1;
              state_q    <= HDR;
            end else begin
              hdr_q   <= 1'b0;
              state_q <= LOAD;
            end
          end
        end
        HDR: begin
          state_q <= WAIT;
        end
        LOAD: begin
          if (gnt_vld_c) begin
            ready_q    <= grant_q;
            tx_data_q  <= gnt_data_c;
            last_q     <= gnt_last_c;
            tx_start_q <= 1'b1;
            to_cnt_q   <= '0;
            state_q    <= SEND;
          end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
            err_q    <= 1'b1;
            grant_q  <= '0;
            ptr_q    <= gid_q;
            busy_q   <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= IDLE;
          end else if (TO_EN) begin
            to_cnt_q <= to_cnt_q + NB_TO'(1);
          end
        end
        SEND: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= LOAD;
            end else if (last_q) begin
              ptr_q   <= gid_q;
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = ready_q;
  assign o_grant       = grant_q;
  assign o_tx_start    = tx_start_q;
  assign o_tx_data     = tx_data_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one uart_tx serializer between N_REQ byte-stream requesters. It grants one requester per packet, optionally prepends a source-ID header byte, and pulses the serializer start strobe. It waits for the serializer's done pulse before each next byte. It sits between the protocol/command blocks and uart_tx, whose i_tx_start, i_tx_data and o_tx_done it drives and observes.

Parameters:
N_REQ, 4, number of requesters (1..16)
NB_DATA, 8, byte width; must match the serializer
HDR_EN, 1, 1 = send a header byte {HDR_TAG, id} before each packet
HDR_TAG, 4'hA, upper nibble of the header byte
TIMEOUT, 1023, max idle cycles mid-packet waiting for the next byte before the grant is forcibly released
NB_TO, 10, timeout counter width (must hold TIMEOUT)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous, active-low reset
i_req_valid  in  N_REQ  per-requester byte valid
i_req_data  in  N_REQ*NB_DATA  per-requester byte; requester k occupies bits [k*NB_DATA +: NB_DATA]
i_req_last  in  N_REQ  marks the last byte of a packet
o_req_ready  out  N_REQ  one-hot byte-accept pulse
o_grant  out  N_REQ  one-hot current owner; 0 when idle
o_tx_start  out  1  one-cycle start strobe to the serializer
o_tx_data  out  NB_DATA  byte to the serializer; held stable from start until done
i_tx_done  in  1  one-cycle done pulse from the serializer
o_busy  out  1  high whenever state != IDLE
o_err_timeout  out  1  one-cycle pulse when a grant is dropped on timeout

Behaviour:
- Reset (async, i_reset_n=0) forces every output and register to 0, with one exception: the RR pointer resets to N_REQ-1, so requester 0 wins first. Reset mid-frame abandons the packet; no done is awaited.
- States: IDLE, HDR, LOAD, SEND, WAIT.
- IDLE: if any i_req_valid is set, pick the first set bit searching from ptr+1 with wrap. Register the one-hot o_grant and the index gid.
  - Next state: HDR if HDR_EN, else LOAD.
  - Arbitration takes 1 cycle; there is no arbitration while granted (packet lock).
- HDR: o_tx_data <= {HDR_TAG, gid[3:0]} (zero-extended/truncated to NB_DATA); o_tx_start=1 for exactly one cycle; -> WAIT (hdr flag set).
- LOAD: the timeout counter runs while the granted valid is low.
  - If the granted valid is high: o_req_ready[gid]=1 for that cycle; capture data into o_tx_data and last into last_q; clear the counter; -> SEND.
  - If the counter reaches TIMEOUT: pulse o_err_timeout, clear o_grant, ptr<=gid, -> IDLE.
- SEND: o_tx_start=1 for one cycle -> WAIT.
- WAIT: hold o_tx_data and ignore requesters until i_tx_done=1. On done:
  - if the header was just sent -> LOAD;
  - else if last_q -> ptr<=gid, o_grant<=0, -> IDLE;
  - else -> LOAD.
- Minimum gap from done to the next start is 2 cycles (LOAD then SEND). This guarantees the serializer has returned to idle before the next strobe is sampled.
- i_tx_done outside WAIT is ignored.
- o_tx_start is never asserted outside HDR/SEND; at most one start is outstanding.
- Requester valids/data are sampled only in IDLE (valid) and LOAD (granted index). Non-granted ready stays 0.
- Simultaneous done and a new valid on another requester: the new request waits until IDLE; the round-robin order guarantees it is served before the finishing requester again.
- The timeout counter saturates and never wraps. TIMEOUT=0 disables the timeout.
- Width rule: gid is $clog2(N_REQ) bits (min 1); the header uses its low 4 bits.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (IDLE..WAIT);
  - NB_DATA default 8;
  - the HDR_TAG default.
- One sub-module is natural: rr_arbiter (N_REQ parameter). Inputs: req vector, pointer. Output: one-hot grant plus index. Purely combinational and reusable by a future rx dispatcher.

Test Plan:
- Single packet, HDR_EN=1: requester 2 sends bytes 0x55 then 0x3C with last. Required serializer sequence is 0xA2, 0x55, 0x3C. There must be exactly 3 start pulses, each issued only after the prior done, and o_grant=4'b0100 throughout.
- Round robin: all 4 requesters hold a 1-byte packet from reset. Grant order must be 0,1,2,3,0. Requester 0 re-requests immediately, yet requester 1 is still served before 0 again.
- Timeout: TIMEOUT=20; requester 1 sends 0x11 without last, then drops valid. Required: o_err_timeout pulses once, 20 cycles after entering LOAD. After it, o_grant=0 and requester 2 (pending) is granted next.
- Done back-pressure: delay i_tx_done by 160 cycles. o_tx_data must stay stable and no start may be issued meanwhile. After done, the next start occurs no earlier than 2 cycles later.
- Reset mid-packet: assert i_reset_n=0 in WAIT. All outputs drop to 0 immediately. After release, requester 0 is granted first.
- HDR_EN=0, N_REQ=1: 3-byte packet 0x01,0x02,0x03 is emitted without a header. o_req_ready pulses exactly 3 times.
